// File: rtl/cf_pkg.sv
// Shared types and timing defaults for the CompactFlash access sequencer.
// Widths, state encoding and counter-load helper live here.
package cf_pkg;

    localparam int CF_ADDR_W = 11;
    localparam int CF_DATA_W = 8;
    localparam int CNT_W     = 8;

    localparam int DEF_SETUP_CYC    = 2;
    localparam int DEF_PULSE_CYC    = 6;
    localparam int DEF_HOLD_CYC     = 2;
    localparam int DEF_WAIT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAITX,
        HOLD,
        DONE
    } cf_state_e;

    // A phase of n clocks loads n-1 and exits on the clock it reads zero.
    function automatic logic [CNT_W-1:0] cyc_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/cf_access_sequencer_if.sv
// Minibus request side and CF card pins of the access sequencer.
// slave is the sequencer view; master is the minibus/card view.
interface cf_access_sequencer_if;
    import cf_pkg::*;

    logic                 req;
    logic                 req_rw_b;
    logic                 req_reg;
    logic [CF_ADDR_W-1:0] req_addr;
    logic [CF_DATA_W-1:0] req_wdata;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic [CF_DATA_W-1:0] rdata;
    logic [CF_ADDR_W-1:0] cf_address;
    logic [CF_DATA_W-1:0] cf_data_out;
    logic                 cf_data_oe;
    logic [CF_DATA_W-1:0] cf_data_in;
    logic                 cf_ce_b;
    logic                 cf_oe_b;
    logic                 cf_we_b;
    logic                 cf_reg_b;
    logic                 cf_wait_b;

    modport slave (
        input  req, req_rw_b, req_reg, req_addr, req_wdata,
        input  cf_data_in, cf_wait_b,
        output busy, done, timeout, rdata,
        output cf_address, cf_data_out, cf_data_oe,
        output cf_ce_b, cf_oe_b, cf_we_b, cf_reg_b
    );

    modport master (
        output req, req_rw_b, req_reg, req_addr, req_wdata,
        output cf_data_in, cf_wait_b,
        input  busy, done, timeout, rdata,
        input  cf_address, cf_data_out, cf_data_oe,
        input  cf_ce_b, cf_oe_b, cf_we_b, cf_reg_b
    );

endinterface

// File: rtl/cf_sync2.sv
// Two-flop synchronizer for active-low card status inputs.
// Resets to 1 so an idle (deasserted) input is seen during reset.
module cf_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cf_access_sequencer.sv
// Turns one latched minibus request into a timed CF memory/attribute/IO
// cycle with programmable setup, strobe and hold, honouring cf_wait_b.
module cf_access_sequencer
    import cf_pkg::*;
#(
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int PULSE_CYC    = DEF_PULSE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
    input logic                  clk,
    input logic                  reset,
    cf_access_sequencer_if.slave bus
);

    cf_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 rw_b_q;
    logic                 abort_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 timeout_q;
    logic [CF_DATA_W-1:0] rdata_q;
    logic [CF_ADDR_W-1:0] addr_q;
    logic [CF_DATA_W-1:0] wdata_q;
    logic                 doe_q;
    logic                 ce_b_q;
    logic                 oe_b_q;
    logic                 we_b_q;
    logic                 reg_b_q;
    logic                 wait_s;

    cf_sync2 u_wait_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.cf_wait_b),
        .q_o   (wait_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rw_b_q    <= 1'b1;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            doe_q     <= 1'b0;
            ce_b_q    <= 1'b1;
            oe_b_q    <= 1'b1;
            we_b_q    <= 1'b1;
            reg_b_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_q <= SETUP;
                        cnt_q   <= cyc_load(SETUP_CYC);
                        rw_b_q  <= bus.req_rw_b;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        doe_q   <= ~bus.req_rw_b;
                        ce_b_q  <= 1'b0;
                        reg_b_q <= ~bus.req_reg;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= STROBE;
                        cnt_q   <= cyc_load(PULSE_CYC);
                        oe_b_q  <= ~rw_b_q;
                        we_b_q  <= rw_b_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (!wait_s) begin
                        state_q <= WAITX;
                        cnt_q   <= cyc_load(WAIT_TIMEOUT);
                    end else begin
                        state_q <= HOLD;
                        cnt_q   <= cyc_load(HOLD_CYC);
                        oe_b_q  <= 1'b1;
                        we_b_q  <= 1'b1;
                        if (rw_b_q) rdata_q <= bus.cf_data_in;
                    end
                end
                WAITX: begin
                    // Timeout leaves rdata untouched; only a real release captures.
                    if (wait_s) begin
                        state_q <= HOLD;
                        cnt_q   <= cyc_load(HOLD_CYC);
                        oe_b_q  <= 1'b1;
                        we_b_q  <= 1'b1;
                        if (rw_b_q) rdata_q <= bus.cf_data_in;
                    end else if (cnt_q == '0) begin
                        state_q <= HOLD;
                        cnt_q   <= cyc_load(HOLD_CYC);
                        oe_b_q  <= 1'b1;
                        we_b_q  <= 1'b1;
                        abort_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        ce_b_q    <= 1'b1;
                        reg_b_q   <= 1'b1;
                        doe_q     <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= abort_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.rdata       = rdata_q;
    assign bus.cf_address  = addr_q;
    assign bus.cf_data_out = wdata_q;
    assign bus.cf_data_oe  = doe_q;
    assign bus.cf_ce_b     = ce_b_q;
    assign bus.cf_oe_b     = oe_b_q;
    assign bus.cf_we_b     = we_b_q;
    assign bus.cf_reg_b    = reg_b_q;

endmodule

// File: tb/tb_cf_access_sequencer.sv
// Scoreboard bench for cf_access_sequencer: directed requests push expected
// cycle shapes; a negedge monitor measures each cycle and checks on done.
module tb_cf_access_sequencer;

    logic clk;
    logic reset;

    cf_access_sequencer_if bus();

    cf_access_sequencer #(
        .SETUP_CYC    (2),
        .PULSE_CYC    (6),
        .HOLD_CYC     (2),
        .WAIT_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rdata;
        logic        to;
        int          setup;
        int          pulse;
        int          hold;
        int          lat;
        logic        rd;
        logic        reg_b;
        logic [10:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor state
    logic        busy_prev = 1'b0;
    logic        inflight  = 1'b0;
    logic        ce_seen;
    int          m_setup, m_pulse, m_hold, m_lat;
    logic        oe_seen, we_seen, both_low, strb_no_ce;
    logic        regb_hi, regb_lo, doe_hi, doe_lo;
    logic [10:0] m_addr;
    logic [7:0]  m_dout;

    always @(negedge clk) begin
        if (reset) begin
            inflight  = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (bus.busy && !busy_prev) begin
                inflight   = 1'b1;
                ce_seen    = 1'b0;
                m_setup    = 0;
                m_pulse    = 0;
                m_hold     = 0;
                m_lat      = 0;
                oe_seen    = 1'b0;
                we_seen    = 1'b0;
                both_low   = 1'b0;
                strb_no_ce = 1'b0;
                regb_hi    = 1'b0;
                regb_lo    = 1'b0;
                doe_hi     = 1'b0;
                doe_lo     = 1'b0;
                m_addr     = '0;
                m_dout     = '0;
            end
            if (inflight) begin
                m_lat++;
                if (bus.cf_ce_b && (!bus.cf_oe_b || !bus.cf_we_b))
                    strb_no_ce = 1'b1;
                if (!bus.cf_ce_b) begin
                    if (!ce_seen) begin
                        m_addr  = bus.cf_address;
                        m_dout  = bus.cf_data_out;
                        ce_seen = 1'b1;
                    end
                    if (!bus.cf_oe_b && !bus.cf_we_b) both_low = 1'b1;
                    if (!bus.cf_oe_b) oe_seen = 1'b1;
                    if (!bus.cf_we_b) we_seen = 1'b1;
                    if (!bus.cf_oe_b || !bus.cf_we_b) m_pulse++;
                    else if (m_pulse == 0) m_setup++;
                    else m_hold++;
                    if (bus.cf_reg_b) regb_hi = 1'b1;
                    else regb_lo = 1'b1;
                    if (bus.cf_data_oe) doe_hi = 1'b1;
                    else doe_lo = 1'b1;
                end
            end
            if (bus.done) begin
                if (sb.size() == 0 || !inflight) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", bus.rdata, e.rdata);
                    chk("timeout", bus.timeout, e.to);
                    chk("setup_clks", m_setup, e.setup);
                    chk("pulse_clks", m_pulse, e.pulse);
                    chk("hold_clks", m_hold, e.hold);
                    chk("latency", m_lat, e.lat);
                    chk("oe_used", oe_seen, e.rd);
                    chk("we_used", we_seen, !e.rd);
                    chk("oe_we_both_low", both_low, 0);
                    chk("strobe_without_ce", strb_no_ce, 0);
                    chk("reg_b_high", regb_hi, e.reg_b);
                    chk("reg_b_low", regb_lo, !e.reg_b);
                    chk("address", m_addr, e.addr);
                    chk("data_oe_high", doe_hi, !e.rd);
                    chk("data_oe_low", doe_lo, e.rd);
                    if (!e.rd) chk("data_out", m_dout, e.wdata);
                end
                inflight = 1'b0;
            end
            busy_prev = bus.busy;
        end
    end

    task automatic expect_cyc(input logic rd, input logic rg,
                              input logic [10:0] a, input logic [7:0] wd,
                              input logic [7:0] rdat, input logic to,
                              input int pulse, input int lat);
        exp_t e;
        e.rdata = rdat;
        e.to    = to;
        e.setup = 2;
        e.pulse = pulse;
        e.hold  = 2;
        e.lat   = lat;
        e.rd    = rd;
        e.reg_b = !rg;
        e.addr  = a;
        e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic rd, input logic rg,
                           input logic [10:0] a, input logic [7:0] wd);
        bus.req_rw_b  = rd;
        bus.req_reg   = rg;
        bus.req_addr  = a;
        bus.req_wdata = wd;
    endtask

    // Drive req for one edge; returns #1 after the accepting edge.
    task automatic pulse_req();
        bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < lim);
        if (!bus.done) begin
            checks++;
            failures++;
            $display("FAIL done_wait: no done within %0d clks", lim);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int gap;

    initial begin
        reset          = 1'b1;
        bus.req        = 1'b0;
        bus.cf_wait_b  = 1'b1;
        bus.cf_data_in = 8'h00;
        set_req(1'b1, 1'b0, 11'h000, 8'h00);
        #12;
        chk("rst_ce_b", bus.cf_ce_b, 1);
        chk("rst_oe_b", bus.cf_oe_b, 1);
        chk("rst_we_b", bus.cf_we_b, 1);
        chk("rst_reg_b", bus.cf_reg_b, 1);
        chk("rst_data_oe", bus.cf_data_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_address", bus.cf_address, 0);
        chk("rst_data_out", bus.cf_data_out, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain read at default timing
        bus.cf_data_in = 8'h5A;
        set_req(1'b1, 1'b0, 11'h1F7, 8'h00);
        expect_cyc(1'b1, 1'b0, 11'h1F7, 8'h00, 8'h5A, 1'b0, 6, 11);
        pulse_req();
        wait_done(40);
        @(posedge clk);
        #1;

        // Attribute write
        set_req(1'b0, 1'b1, 11'h200, 8'h80);
        expect_cyc(1'b0, 1'b1, 11'h200, 8'h80, 8'h5A, 1'b0, 6, 11);
        pulse_req();
        wait_done(40);
        @(posedge clk);
        #1;

        // Wait extension: low from strobe clk 2 for 10 clks
        bus.cf_data_in = 8'h11;
        set_req(1'b1, 1'b0, 11'h010, 8'h00);
        expect_cyc(1'b1, 1'b0, 11'h010, 8'h00, 8'hC3, 1'b0, 14, 19);
        pulse_req();
        repeat (3) @(posedge clk);
        #1 bus.cf_wait_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.cf_wait_b  = 1'b1;
        bus.cf_data_in = 8'hC3;
        wait_done(60);
        @(posedge clk);
        #1;

        // Wait stuck low: abort after 16 wait clocks
        bus.cf_wait_b  = 1'b0;
        bus.cf_data_in = 8'hEE;
        set_req(1'b1, 1'b1, 11'h3FF, 8'h00);
        expect_cyc(1'b1, 1'b1, 11'h3FF, 8'h00, 8'hC3, 1'b1, 22, 27);
        pulse_req();
        wait_done(80);
        bus.cf_wait_b = 1'b1;
        @(posedge clk);
        #1;
        chk("timeout_cleared", bus.timeout, 0);
        repeat (3) @(posedge clk);
        #1;

        // Request pulsed during strobe is dropped
        bus.cf_data_in = 8'h21;
        set_req(1'b1, 1'b0, 11'h055, 8'h00);
        expect_cyc(1'b1, 1'b0, 11'h055, 8'h00, 8'h21, 1'b0, 6, 11);
        pulse_req();
        repeat (3) @(posedge clk);
        #1 bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        wait_done(40);
        repeat (6) @(posedge clk);
        #1;
        chk("ignored_req_busy", bus.busy, 0);

        // Request held through done: back-to-back writes
        set_req(1'b0, 1'b0, 11'h101, 8'h3C);
        expect_cyc(1'b0, 1'b0, 11'h101, 8'h3C, 8'h21, 1'b0, 6, 11);
        expect_cyc(1'b0, 1'b0, 11'h101, 8'h3C, 8'h21, 1'b0, 6, 11);
        bus.req = 1'b1;
        wait_done(40);
        gap = 0;
        @(negedge clk);
        while (!bus.busy && gap < 5) begin
            gap++;
            @(negedge clk);
        end
        chk("busy_gap", gap, 1);
        bus.req = 1'b0;
        wait_done(40);
        @(posedge clk);
        #1;

        // Async reset in the middle of a strobe
        bus.cf_data_in = 8'h44;
        set_req(1'b1, 1'b0, 11'h123, 8'h00);
        pulse_req();
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_oe_b", bus.cf_oe_b, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ce_b", bus.cf_ce_b, 1);
        chk("mid_rst_oe_b", bus.cf_oe_b, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Normal read after reset recovery
        bus.cf_data_in = 8'h99;
        set_req(1'b1, 1'b1, 11'h7FF, 8'h00);
        expect_cyc(1'b1, 1'b1, 11'h7FF, 8'h00, 8'h99, 1'b0, 6, 11);
        pulse_req();
        wait_done(40);
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
